rf_writeback_queue: RTL

//   Writer end of the register-file write port. Buffers committed write requests
//   (ALU results, late load data) in an in-order FIFO. Drains one entry per cycle

---
 rtl/rf_writeback_queue.sv | 130 +++++++++++++
 1 files changed

// File: rtl/rf_writeback_queue.sv
// ---------------------------------------------------------------------------
// rf_writeback_queue
//   Writer end of the register-file write port. Committed write requests are
//   buffered in an in-order FIFO and drained one per cycle onto the register
//   file's WE / W_in / Din inputs through a registered output stage. Two
//   combinational forwarding ports let the read stage see values that have
//   not reached the register file yet.
//
// Ports
//   i_clk                      system clock, all state on posedge
//   i_rst_n                    synchronous active-low reset
//   i_wr_valid / o_wr_ready    producer handshake
//   i_wr_addr / i_wr_data      destination register and value
//   o_rf_we / o_rf_waddr / o_rf_wdata   registered register-file write port
//   i_fwd_addrN -> o_fwd_hitN / o_fwd_dataN   forwarding lookups (N = 1, 2)
//   o_empty                    queue and output stage both idle
// ---------------------------------------------------------------------------
module rf_writeback_queue #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_wr_valid,
    output logic             o_wr_ready,
    input  logic [4:0]       i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    output logic             o_rf_we,
    output logic [4:0]       o_rf_waddr,
    output logic [WIDTH-1:0] o_rf_wdata,
    input  logic [4:0]       i_fwd_addr1,
    output logic             o_fwd_hit1,
    output logic [WIDTH-1:0] o_fwd_data1,
    input  logic [4:0]       i_fwd_addr2,
    output logic             o_fwd_hit2,
    output logic [WIDTH-1:0] o_fwd_data2,
    output logic             o_empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [4:0]       r_q_addr [DEPTH];
    logic [WIDTH-1:0] r_q_data [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [PTR_W:0]   r_count;

    logic w_not_full;
    logic w_push;
    logic w_pop;

    assign w_not_full = (int'(r_count) < DEPTH);
    // Writes to r0 complete the handshake but never enter the queue.
    assign w_push     = i_wr_valid & w_not_full & (i_wr_addr != 5'd0);
    assign w_pop      = (r_count != '0);

    assign o_wr_ready = i_rst_n & w_not_full;
    assign o_empty    = ~i_rst_n | ((r_count == '0) & ~o_rf_we);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            o_rf_we    <= 1'b0;
            o_rf_waddr <= 5'd0;
            o_rf_wdata <= '0;
        end else begin
            if (w_pop) begin
                o_rf_we    <= 1'b1;
                o_rf_waddr <= r_q_addr[r_rptr];
                o_rf_wdata <= r_q_data[r_rptr];
                r_rptr     <= r_rptr + 1'b1;
            end else begin
                o_rf_we    <= 1'b0;
            end
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset; validity is tracked by r_count alone.
    always_ff @(posedge i_clk) begin
        if (i_rst_n && w_push) begin
            r_q_addr[r_wptr] <= i_wr_addr;
            r_q_data[r_wptr] <= i_wr_data;
        end
    end

    // Oldest candidate first so that each later match overrides: output
    // stage, then queue entries from head to tail (youngest wins).
    function automatic logic [WIDTH:0] fwd_lookup(input logic [4:0] addr);
        logic [WIDTH:0]   res;
        logic [PTR_W-1:0] idx;
        res = '0;
        if (o_rf_we && (o_rf_waddr == addr)) begin
            res = {1'b1, o_rf_wdata};
        end
        for (int i = 0; i < DEPTH; i++) begin
            idx = r_rptr + PTR_W'(i);
            if ((i < int'(r_count)) && (r_q_addr[idx] == addr)) begin
                res = {1'b1, r_q_data[idx]};
            end
        end
        if (!i_rst_n || (addr == 5'd0)) begin
            res = '0;
        end
        return res;
    endfunction

    logic [WIDTH:0] w_fwd1;
    logic [WIDTH:0] w_fwd2;

    always_comb begin
        w_fwd1 = fwd_lookup(i_fwd_addr1);
        w_fwd2 = fwd_lookup(i_fwd_addr2);
    end

    assign o_fwd_hit1  = w_fwd1[WIDTH];
    assign o_fwd_data1 = w_fwd1[WIDTH-1:0];
    assign o_fwd_hit2  = w_fwd2[WIDTH];
    assign o_fwd_data2 = w_fwd2[WIDTH-1:0];

endmodule
